// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_pkg : shared types and constants for the MUL operand issue path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mul_pkg;

  localparam int WIDTH_LOG = 2;
  localparam int WIDTH     = 1 << WIDTH_LOG;
  localparam int OUT_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mul_issue_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } mul_op_t;

endpackage
`default_nettype wire

// File: rtl/mul_op_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_op_fifo : synchronous FIFO of MUL operand pairs                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mul_op_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH_LOG = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  mul_op_t            i_wdata,
  output mul_op_t            o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH_LOG:0] o_level
);

  localparam int C_DEPTH = 1 << DEPTH_LOG;

  mul_op_t              r_mem [C_DEPTH];
  logic [DEPTH_LOG:0]   r_wr_ptr;
  logic [DEPTH_LOG:0]   r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG] != r_rd_ptr[DEPTH_LOG]) &&
                   (r_wr_ptr[DEPTH_LOG-1:0] == r_rd_ptr[DEPTH_LOG-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[DEPTH_LOG-1:0]];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_issue_queue : buffers operand pairs and issues them to the MUL    |
// | one at a time. Optional WAIT watchdog: MUL_ISSUE_TIMEOUT_EN           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mul_issue_queue
  import mul_pkg::*;
#(
  parameter int WIDTH     = mul_pkg::WIDTH,
  parameter int DEPTH_LOG = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               mul_in_valid,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  output logic [DEPTH_LOG:0] level,
  output logic               timeout_err
);

  mul_issue_state_t r_state;
  logic             r_in_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_timeout_err;

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  logic    w_timeout;
  mul_op_t w_head;
  mul_op_t w_wdata;

  assign w_push    = req_valid && !w_full;
  assign w_wdata.a = req_a;
  assign w_wdata.b = req_b;

  mul_op_fifo #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

`ifdef MUL_ISSUE_TIMEOUT_EN
  localparam int                 C_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'(TIMEOUT - 1);

  logic [C_CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT && r_wait_cnt != '1) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`endif

  // Head leaves the queue only when the outstanding op retires; done beats timeout.
  always_comb begin
    w_pop     = 1'b0;
    w_timeout = 1'b0;
    if (r_state == WAIT) begin
      if (mul_done) begin
        w_pop = 1'b1;
      end
`ifdef MUL_ISSUE_TIMEOUT_EN
      else if (r_wait_cnt == C_TMO_LAST) begin
        w_pop     = 1'b1;
        w_timeout = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_in_valid    <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_in_valid    <= 1'b0;
      r_timeout_err <= w_timeout;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= ISSUE;
            r_in_valid <= 1'b1;
            r_a        <= w_head.a;
            r_b        <= w_head.b;
          end
        end
        ISSUE:   r_state <= WAIT;
        WAIT:    if (w_pop) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = !w_full;
  assign mul_in_valid = r_in_valid;
  assign mul_a        = r_a;
  assign mul_b        = r_b;
  assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire
